cv32e40p_mac_mem_seq: RTL
=========================

// Module: cv32e40p_mac_mem_seq
// PURPOSE
// Memory-side sequencer for the CNN MAC/convolution unit. It walks a word-strided buffer over the core's
// OBI data port and serves two kinds of request:
// - read bursts (convolution tiles, max-pool inputs): streams words into the MAC unit with a 1-based
//   word counter;
// - write bursts (Winograd y0..y3 write-back): fetches each word from the MAC unit, indexed by a
//   0-based counter, and stores it.
// It owns the con_data_cnt / mem_rdata / mem_wdata side of the MAC interface.
// PARAMETERS
// MAX_OUTST   2   max read/write requests granted but not yet answered by rvalid (1..3)
// CNT_W       5   width of burst length field (max length 16)
// PORTS
// clk            in   1      clock, all logic on rising edge
// rst            in   1      synchronous, active-high reset
// start_rd_i     in   1      pulse: begin read burst
// start_wr_i     in   1      pulse: begin write burst
// len_i          in   CNT_W  burst length in words, 1..16; sampled at start
// base_addr_i    in   32     byte address of word 0; sampled at start, must be word aligned
// stride_i       in   32     byte increment between words; sampled at start
// mem_wdata_i    in   32     write word from the MAC unit, selected by con_data_cnt_o
// con_data_cnt_o out  32     word counter seen by the MAC unit
// mem_rdata_o    out  32     read word; matches con_data_cnt_o
// rdata_valid_o  out  1      1-cycle pulse when mem_rdata_o/con_data_cnt_o update
// busy_o         out  1      high from the cycle after an accepted start until the cycle after DONE
// done_o         out  1      1-cycle pulse in DONE
// err_o          out  1      1-cycle pulse when a start is rejected
// data_req_o     out  1      OBI request
// data_gnt_i     in   1      OBI grant
// data_addr_o    out  32     OBI address
// data_we_o      out  1      OBI write enable
// data_be_o      out  4      OBI byte enables, always 4'hF
// data_wdata_o   out  32     OBI write data
// data_rvalid_i  in   1      OBI response valid
// data_rdata_i   in   32     OBI read data
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0, except data_be_o = 4'hF. All internal counters 0.
// - Reset mid-burst aborts with no done_o. A late data_rvalid_i in IDLE is ignored.
// - FSM states: IDLE, RD, WR, DRAIN, DONE.
// - IDLE: con_data_cnt_o = 0.
//   - start_rd_i moves to RD; else start_wr_i moves to WR. Operands are latched.
//   - A start is rejected, with err_o and the FSM staying in IDLE, when len_i = 0, when len_i > 16, or
//     when base_addr_i[1:0] != 0.
//   - start_rd_i and start_wr_i in the same cycle: read is accepted, write is dropped, err_o = 1.
//   - Starts outside IDLE are ignored and give no err_o.
// - Issue rules (RD and WR):
//   - data_req_o = 1 while issued < len and outstanding < MAX_OUTST.
//   - data_addr_o = base + issued*stride, mod 2^32 (wraps silently).
//   - addr, we and wdata stay stable while req is high without gnt.
//   - issued increments on req & gnt.
//   - outstanding is +1 on req & gnt and -1 on rvalid; both in the same cycle leave it unchanged.
// - RD:
//   - data_we_o = 0.
//   - On each data_rvalid_i, in the next cycle: mem_rdata_o <= data_rdata_i,
//     con_data_cnt_o <= con_data_cnt_o + 1, rdata_valid_o = 1.
//   - Word k therefore appears with count k (1-based).
//   - mem_rdata_o and con_data_cnt_o hold between responses.
//   - When the len-th response is registered, go to DONE.
// - WR:
//   - data_we_o = 1. data_wdata_o = mem_wdata_i, combinational; the MAC unit selects y[count].
//   - con_data_cnt_o is 0-based and increments on each req & gnt, so the next word is presented in the
//     following cycle.
//   - After the len-th grant, go to DRAIN. Write rvalids only decrement outstanding.
// - DRAIN: no requests. Go to DONE when outstanding = 0; con_data_cnt_o holds len.
// - DONE, one cycle: done_o = 1, then IDLE.
//   - Read burst: con_data_cnt_o = len+1, so the MAC unit's "count < len+1" exit condition is met.
//   - Write burst: con_data_cnt_o = len.
// - Response order matches request order. There are no error responses.
// - Latency: with gnt tied high and rvalid one cycle after gnt, an N-word read takes N+3 cycles from
//   start to done_o.
// TESTING
// - 16-word read, base 0x1000, stride 4, gnt=1, rvalid 1 cycle after gnt:
//   -> addrs 0x1000..0x103C; count 1..16 paired with rdata; done_o at cycle 19.
// - 4-word write, stride 0x40, MAC drives mem_wdata_i = 0xA0+count:
//   -> writes 0xA0..0xA3 to base, +0x40, +0x80, +0xC0; count ends at 4; done_o after the last rvalid.
// - gnt low for 3 cycles on word 2:
//   -> req/addr/wdata held stable; outstanding never exceeds MAX_OUTST=2.
// - Rejected starts:
//   - len 0 -> err_o=1, busy_o=0;
//   - base 0x1002 -> err_o=1;
//   - start_rd & start_wr together -> read runs, err_o=1.
// - Reset asserted mid 8-word read after 3 responses, then a stray rvalid:
//   -> all outputs 0 (be=F), no done_o, stray rvalid ignored, next burst correct.
// - base 0xFFFFFFF8, stride 8, len 3:
//   -> addrs 0xFFFFFFF8, 0x00000000, 0x00000008.

Source files
------------

// File: rtl/cv32e40p_mac_mem_seq.sv
// Memory-side sequencer for the CNN MAC unit: walks a word-strided buffer over OBI,
// streaming read words into the MAC (1-based count) or storing MAC words (0-based count).
//
// state | meaning
// IDLE  | waiting for a start; count held at 0
// RD    | issuing reads, registering each response with count k = 1..len
// WR    | issuing writes of mem_wdata_i, count = index of the word being presented
// DRAIN | all writes granted, waiting for their responses
// DONE  | one-cycle completion pulse
module cv32e40p_mac_mem_seq #(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_rd_i,
   input  logic             start_wr_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic [31:0]      base_addr_i,
   input  logic [31:0]      stride_i,
   input  logic [31:0]      mem_wdata_i,
   output logic [31:0]      con_data_cnt_o,
   output logic [31:0]      mem_rdata_o,
   output logic             rdata_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             data_req_o,
   input  logic             data_gnt_i,
   output logic [31:0]      data_addr_o,
   output logic             data_we_o,
   output logic [3:0]       data_be_o,
   output logic [31:0]      data_wdata_o,
   input  logic             data_rvalid_i,
   input  logic [31:0]      data_rdata_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int               OUT_W   = 2;
   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(16);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] issued_q;
   logic [OUT_W-1:0] outst_q;
   logic [31:0]      stride_q;
   logic [31:0]      addr_q;
   logic [31:0]      cnt_q;
   logic [31:0]      rdata_q;
   logic             rvalid_q;
   logic             err_q;

   logic             bad_len;
   logic             bad_addr;
   logic             start_ok;
   logic             err_d;
   logic             active;
   logic             issuing;
   logic             fire;
   logic             rsp;

   assign bad_len  = (len_i == '0) || (len_i > LEN_MAX);
   assign bad_addr = (base_addr_i[1:0] != 2'b00);

   assign active  = (state_q == S_RD) || (state_q == S_WR);
   assign issuing = active && (issued_q < len_q) && (outst_q < OUT_W'(MAX_OUTST));
   assign fire    = issuing && data_gnt_i;
   // responses only count while a burst can have requests in flight; late ones in IDLE are dropped
   assign rsp     = data_rvalid_i && (state_q != S_IDLE) && (state_q != S_DONE) && (outst_q != '0);

   always_comb begin
      state_d  = state_q;
      err_d    = 1'b0;
      start_ok = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_rd_i) begin
               if (bad_len || bad_addr) begin
                  err_d = 1'b1;
               end else begin
                  start_ok = 1'b1;
                  state_d  = S_RD;
               end
               // a simultaneous write request is always dropped
               if (start_wr_i) begin
                  err_d = 1'b1;
               end
            end else if (start_wr_i) begin
               if (bad_len || bad_addr) begin
                  err_d = 1'b1;
               end else begin
                  start_ok = 1'b1;
                  state_d  = S_WR;
               end
            end
         end
         S_RD: begin
            if (cnt_q == 32'(len_q)) begin
               state_d = S_DONE;
            end
         end
         S_WR: begin
            if (fire && ((issued_q + CNT_W'(1)) == len_q)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (outst_q == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         issued_q <= '0;
         outst_q  <= '0;
         stride_q <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         err_q    <= err_d;
         rvalid_q <= 1'b0;

         if (start_ok) begin
            len_q    <= len_i;
            stride_q <= stride_i;
            addr_q   <= base_addr_i;
            issued_q <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
         end

         if (fire) begin
            issued_q <= issued_q + CNT_W'(1);
            addr_q   <= addr_q + stride_q;
         end

         case ({fire, rsp})
            2'b10:   outst_q <= outst_q + OUT_W'(1);
            2'b01:   outst_q <= outst_q - OUT_W'(1);
            default: outst_q <= outst_q;
         endcase

         if ((state_q == S_RD) && rsp) begin
            rdata_q  <= data_rdata_i;
            cnt_q    <= cnt_q + 32'd1;
            rvalid_q <= 1'b1;
         end

         if ((state_q == S_WR) && fire) begin
            cnt_q <= cnt_q + 32'd1;
         end

         // read bursts finish with len+1 so the MAC loop "count < len+1" terminates
         if ((state_q == S_RD) && (state_d == S_DONE)) begin
            cnt_q <= 32'(len_q) + 32'd1;
         end

         if (state_q == S_DONE) begin
            cnt_q <= '0;
         end
      end
   end

   assign data_req_o     = issuing;
   assign data_addr_o    = active ? addr_q : 32'h0;
   assign data_we_o      = (state_q == S_WR);
   assign data_wdata_o   = (state_q == S_WR) ? mem_wdata_i : 32'h0;
   assign data_be_o      = 4'hF;
   assign con_data_cnt_o = cnt_q;
   assign mem_rdata_o    = rdata_q;
   assign rdata_valid_o  = rvalid_q;
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign err_o          = err_q;

endmodule
